// File: rtl/sseg_frame_if.sv
// sseg_frame_if -- frame hand-off between a display source and sseg_scan.
//
//   frame_digits [23:0]  six BCD digits, [23:20] is position 0 (leftmost)
//   frame_dots   [5:0]   decimal-point mask, bit 5 is position 0, 1 = lit
//   frame_valid          source offers a frame
//   frame_ready          scanner can take a frame this cycle
//
// master: the frame source.  slave: the scanner.
interface sseg_frame_if;
  logic [23:0] frame_digits;
  logic [5:0]  frame_dots;
  logic        frame_valid;
  logic        frame_ready;

  modport master (
    output frame_digits,
    output frame_dots,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_digits,
    input  frame_dots,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/sseg_scan.sv
// sseg_scan -- six-position multiplexed seven-segment scanner.
//
// Holds each position for DIV clocks and walks digit_pos 0..5.  Frames are
// accepted into a one-entry pending buffer and promoted to the active buffer
// only on the 5->0 step, so a scan never mixes two frames.
//
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   frm        frame hand-off (slave side of sseg_frame_if)
//   digit      {dot lit, BCD nibble} for the current position
//   digit_pos  current position 0..5
//   scan_wrap  one-cycle pulse in the first cycle of position 0
//   bcd_err    sticky: some accepted frame carried a nibble above 9
module sseg_scan #(
  parameter int unsigned DIV = 50000
) (
  input  logic         clk,
  input  logic         rst,
  sseg_frame_if.slave  frm,
  output logic [4:0]   digit,
  output logic [2:0]   digit_pos,
  output logic         scan_wrap,
  output logic         bcd_err
);

  localparam logic [15:0] PRESC_LAST = 16'(DIV - 1);

  logic [15:0] presc_q, presc_d;
  logic [2:0]  pos_q, pos_d;
  logic [4:0]  digit_q, digit_d;
  logic [23:0] act_dig_q, act_dig_d;
  logic [5:0]  act_dot_q, act_dot_d;
  logic [23:0] pend_dig_q, pend_dig_d;
  logic [5:0]  pend_dot_q, pend_dot_d;
  logic        pend_full_q, pend_full_d;
  logic        wrap_q, wrap_d;
  logic        err_q, err_d;

  logic        tick;
  logic        wrap_edge;
  logic        copy;
  logic        xfer;

  // Nibbles above 9 cannot be shown; they are stored as blank zeros.
  function automatic logic [23:0] bcd_clean(input logic [23:0] d);
    logic [23:0] r;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = (d[i*4 +: 4] > 4'd9) ? 4'd0 : d[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic bcd_bad(input logic [23:0] d);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b = b | (d[i*4 +: 4] > 4'd9);
    end
    return b;
  endfunction

  function automatic logic [4:0] pos_sel(input logic [23:0] dig,
                                         input logic [5:0]  dot,
                                         input logic [2:0]  p);
    logic [4:0] r;
    case (p)
      3'd0:    r = {dot[5], dig[23:20]};
      3'd1:    r = {dot[4], dig[19:16]};
      3'd2:    r = {dot[3], dig[15:12]};
      3'd3:    r = {dot[2], dig[11:8]};
      3'd4:    r = {dot[1], dig[7:4]};
      3'd5:    r = {dot[0], dig[3:0]};
      default: r = 5'b00000;
    endcase
    return r;
  endfunction

  always_comb begin
    tick      = (presc_q == PRESC_LAST);
    wrap_edge = tick && (pos_q == 3'd5);
    // copy needs a full pending buffer and xfer needs an empty one, so the
    // two never coincide; a frame taken on the wrap edge waits a full scan.
    copy      = wrap_edge && pend_full_q;
    xfer      = frm.frame_valid && !pend_full_q;

    presc_d = tick ? 16'd0 : presc_q + 16'd1;

    pos_d = pos_q;
    if (tick) begin
      pos_d = (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;
    end

    act_dig_d = copy ? pend_dig_q : act_dig_q;
    act_dot_d = copy ? pend_dot_q : act_dot_q;

    pend_full_d = pend_full_q;
    if (copy) pend_full_d = 1'b0;
    if (xfer) pend_full_d = 1'b1;

    pend_dig_d = xfer ? bcd_clean(frm.frame_digits) : pend_dig_q;
    pend_dot_d = xfer ? frm.frame_dots : pend_dot_q;

    err_d = err_q | (xfer && bcd_bad(frm.frame_digits));

    // Look ahead to next-state buffer and position so digit and digit_pos
    // update together, including position 0 of a freshly promoted frame.
    digit_d = pos_sel(act_dig_d, act_dot_d, pos_d);
    wrap_d  = wrap_edge;
  end

  // ---- control and display registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= 16'd0;
      pos_q       <= 3'd0;
      digit_q     <= 5'b00000;
      act_dig_q   <= 24'd0;
      act_dot_q   <= 6'd0;
      pend_full_q <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      pos_q       <= pos_d;
      digit_q     <= digit_d;
      act_dig_q   <= act_dig_d;
      act_dot_q   <= act_dot_d;
      pend_full_q <= pend_full_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
    end
  end

  // ---- pending payload (qualified by pend_full_q, so no reset) ----
  always_ff @(posedge clk) begin
    pend_dig_q <= pend_dig_d;
    pend_dot_q <= pend_dot_d;
  end

  assign frm.frame_ready = !pend_full_q;
  assign digit           = digit_q;
  assign digit_pos       = pos_q;
  assign scan_wrap       = wrap_q;
  assign bcd_err         = err_q;

endmodule

// File: tb/tb_sseg_scan.sv
// tb_sseg_scan -- directed bench for sseg_scan with DIV=4.
// t counts cycles since reset release; samples are taken 1 time unit after
// each rising edge, when inputs are also changed.
module tb_sseg_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] digit;
  logic [2:0] digit_pos;
  logic       scan_wrap;
  logic       bcd_err;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  logic [4:0] exp_d [6];

  sseg_frame_if frm_if ();

  sseg_scan #(.DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .frm       (frm_if.slave),
    .digit     (digit),
    .digit_pos (digit_pos),
    .scan_wrap (scan_wrap),
    .bcd_err   (bcd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, expv);
    end
  endtask

  task automatic goto(input int target);
    while (t < target) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic offer(input logic [23:0] d, input logic [5:0] m);
    frm_if.frame_digits = d;
    frm_if.frame_dots   = m;
    frm_if.frame_valid  = 1'b1;
  endtask

  // Check one full scan starting at t0 against exp_d: first and last cycle
  // of every position.
  task automatic chk_scan(input string tag, input int t0);
    for (int p = 0; p < 6; p++) begin
      goto(t0 + 4*p);
      chk({tag, "_digit_first"}, 32'(digit), 32'(exp_d[p]));
      chk({tag, "_pos_first"}, 32'(digit_pos), p);
      goto(t0 + 4*p + 3);
      chk({tag, "_digit_last"}, 32'(digit), 32'(exp_d[p]));
      chk({tag, "_pos_last"}, 32'(digit_pos), p);
    end
  endtask

  initial begin
    frm_if.frame_digits = 24'd0;
    frm_if.frame_dots   = 6'd0;
    frm_if.frame_valid  = 1'b0;

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pos", 32'(digit_pos), 0);
    chk("rst_digit", 32'(digit), 0);
    chk("rst_ready", 32'(frm_if.frame_ready), 1);
    chk("rst_wrap", 32'(scan_wrap), 0);
    chk("rst_err", 32'(bcd_err), 0);
    rst = 1'b0;
    t   = 0;

    // idle scan
    for (int k = 0; k < 48; k++) begin
      goto(k);
      chk("idle_pos", 32'(digit_pos), (k / 4) % 6);
      chk("idle_digit", 32'(digit), 0);
      chk("idle_wrap", 32'(scan_wrap), (k > 0 && k % 24 == 0) ? 1 : 0);
    end

    // single frame mid-scan
    goto(54);
    chk("f1_ready_before", 32'(frm_if.frame_ready), 1);
    offer(24'h123456, 6'b000100);
    goto(55);
    frm_if.frame_valid = 1'b0;
    for (int k = 55; k < 72; k++) begin
      goto(k);
      chk("f1_ready_low", 32'(frm_if.frame_ready), 0);
      chk("f1_no_tear", 32'(digit), 0);
    end
    goto(72);
    chk("f1_ready_back", 32'(frm_if.frame_ready), 1);
    chk("f1_wrap", 32'(scan_wrap), 1);
    goto(73);
    chk("f1_wrap_one", 32'(scan_wrap), 0);
    exp_d = '{5'h01, 5'h02, 5'h03, 5'h14, 5'h05, 5'h06};
    chk_scan("f1", 72);

    // back-to-back frames
    goto(97);
    offer(24'h654321, 6'b000000);
    goto(98);
    offer(24'h789012, 6'b100000);
    for (int k = 98; k < 120; k++) begin
      goto(k);
      chk("b2b_blocked", 32'(frm_if.frame_ready), 0);
    end
    goto(100);
    goto(120);
    chk("b2b_ready", 32'(frm_if.frame_ready), 1);
    goto(121);
    frm_if.frame_valid = 1'b0;
    chk("b2b_second_taken", 32'(frm_if.frame_ready), 0);
    exp_d = '{5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01};
    chk_scan("b2b_a", 120);
    goto(144);
    chk("b2b_ready2", 32'(frm_if.frame_ready), 1);
    exp_d = '{5'h17, 5'h08, 5'h09, 5'h00, 5'h01, 5'h02};
    chk_scan("b2b_b", 144);
    chk("err_clear", 32'(bcd_err), 0);

    // invalid BCD nibbles
    goto(169);
    offer(24'h9A0F01, 6'b000000);
    goto(170);
    frm_if.frame_valid = 1'b0;
    chk("err_set", 32'(bcd_err), 1);
    exp_d = '{5'h09, 5'h00, 5'h00, 5'h00, 5'h00, 5'h01};
    chk_scan("err", 192);

    // transfer on the wrap edge
    goto(215);
    chk("we_pos5", 32'(digit_pos), 5);
    chk("we_ready", 32'(frm_if.frame_ready), 1);
    offer(24'h246802, 6'b010000);
    goto(216);
    frm_if.frame_valid = 1'b0;
    chk("we_taken", 32'(frm_if.frame_ready), 0);
    chk("we_wrap", 32'(scan_wrap), 1);
    chk_scan("we_old", 216);
    exp_d = '{5'h02, 5'h14, 5'h06, 5'h08, 5'h00, 5'h02};
    chk_scan("we_new", 240);
    chk("err_sticky", 32'(bcd_err), 1);

    // reset mid-scan with pending full
    goto(265);
    offer(24'h777777, 6'b111111);
    goto(266);
    frm_if.frame_valid = 1'b0;
    chk("mr_pending", 32'(frm_if.frame_ready), 0);
    goto(276);
    chk("mr_pos3", 32'(digit_pos), 3);
    rst = 1'b1;
    goto(277);
    chk("mr_pos", 32'(digit_pos), 0);
    chk("mr_digit", 32'(digit), 0);
    chk("mr_ready", 32'(frm_if.frame_ready), 1);
    chk("mr_err", 32'(bcd_err), 0);
    chk("mr_wrap", 32'(scan_wrap), 0);
    rst = 1'b0;
    t   = 0;
    for (int k = 0; k < 28; k++) begin
      goto(k);
      chk("mr_scan_pos", 32'(digit_pos), (k / 4) % 6);
      chk("mr_scan_digit", 32'(digit), 0);
      chk("mr_scan_ready", 32'(frm_if.frame_ready), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
